// File: rtl/fpu_f2int_rm_if.sv
// Start/valid handshake bundle for the float-to-integer converter.
// The master drives the operand and rounding mode; the slave returns the result and flags.
interface fpu_f2int_rm_if #(
    parameter int OUT_W = 32
);
    logic             do_f2int;
    logic [31:0]      b;
    logic [1:0]       rmode;
    logic [OUT_W-1:0] q;
    logic             valid;
    logic             busy;
    logic             nv;
    logic             nx;

    modport master (
        output do_f2int, b, rmode,
        input  q, valid, busy, nv, nx
    );

    modport slave (
        input  do_f2int, b, rmode,
        output q, valid, busy, nv, nx
    );
endinterface

// File: rtl/fpu_f2int_rm.sv
// binary32 -> OUT_W-bit integer converter with selectable IEEE rounding and saturation.
// Fixed 4-edge latency: capture, align, round, pack.
module fpu_f2int_rm #(
    parameter int OUT_W      = 32,
    parameter int SIGNED_OUT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fpu_f2int_rm_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ROUND = 2'd2,
        PACK  = 2'd3
    } state_t;

    localparam int W1 = OUT_W + 1;
    // One bit above the aligned magnitude so a rounding carry out of the top bit is never lost.
    localparam int MW = OUT_W + 2;
    localparam logic [MW-1:0] ONE     = MW'(1);
    localparam logic [MW-1:0] POS_LIM = (SIGNED_OUT != 0) ? (ONE << (OUT_W - 1)) - ONE
                                                          : (ONE << OUT_W) - ONE;
    localparam logic [MW-1:0] NEG_LIM = (SIGNED_OUT != 0) ? (ONE << (OUT_W - 1)) : '0;
    localparam logic [OUT_W-1:0] Q_POS = OUT_W'(POS_LIM);
    localparam logic [OUT_W-1:0] Q_NEG = OUT_W'(NEG_LIM);

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic [7:0]       e_q, e_d;
    logic [22:0]      frac_q, frac_d;
    logic [1:0]       rm_q, rm_d;
    logic [W1-1:0]    int_q, int_d;
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic             nan_q, nan_d;
    logic             ovf_q, ovf_d;
    logic [MW-1:0]    mag_q, mag_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             nv_q, nv_d;
    logic             nx_q, nx_d;

    logic [23:0]      mant;
    logic [47:0]      shr;
    logic             inc;
    int               exp_unb;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        s_d      = s_q;
        e_d      = e_q;
        frac_d   = frac_q;
        rm_d     = rm_q;
        int_d    = int_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        nan_d    = nan_q;
        ovf_d    = ovf_q;
        mag_d    = mag_q;
        q_d      = q_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        nv_d     = nv_q;
        nx_d     = nx_q;
        shr      = '0;
        inc      = 1'b0;
        mant     = {e_q != 8'd0, frac_q};
        exp_unb  = (e_q == 8'd0) ? -126 : int'(e_q) - 127;

        case (state_q)
            IDLE: begin
                if (bus.do_f2int) begin
                    s_d     = bus.b[31];
                    e_d     = bus.b[30:23];
                    frac_d  = bus.b[22:0];
                    rm_d    = bus.rmode;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                nan_d    = (e_q == 8'hFF) && (frac_q != 23'd0);
                ovf_d    = 1'b0;
                int_d    = '0;
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                // Infinity and NaN land in the overflow branch because their exponent is 128.
                if (exp_unb > OUT_W) begin
                    ovf_d = 1'b1;
                end else if (exp_unb >= 23) begin
                    int_d = W1'({64'd0, mant} << (exp_unb - 23));
                end else if (exp_unb >= -1) begin
                    shr      = {mant, 24'd0} >> (23 - exp_unb);
                    int_d    = W1'(shr[47:24]);
                    guard_d  = shr[23];
                    sticky_d = |shr[22:0];
                end else begin
                    sticky_d = |mant;
                end
                state_d = ROUND;
            end
            ROUND: begin
                case (rm_q)
                    2'b00:   inc = guard_q & (sticky_q | int_q[0]);
                    2'b01:   inc = 1'b0;
                    2'b10:   inc = !s_q & (guard_q | sticky_q);
                    default: inc = s_q & (guard_q | sticky_q);
                endcase
                mag_d   = MW'(int_q) + MW'(inc);
                state_d = PACK;
            end
            PACK: begin
                if (nan_q) begin
                    q_d  = Q_POS;
                    nv_d = 1'b1;
                end else if (ovf_q) begin
                    q_d  = s_q ? Q_NEG : Q_POS;
                    nv_d = 1'b1;
                end else if (!s_q && (mag_q > POS_LIM)) begin
                    q_d  = Q_POS;
                    nv_d = 1'b1;
                end else if (s_q && (mag_q > NEG_LIM)) begin
                    q_d  = Q_NEG;
                    nv_d = 1'b1;
                end else begin
                    q_d  = s_q ? OUT_W'(-mag_q) : OUT_W'(mag_q);
                    nv_d = 1'b0;
                end
                nx_d    = (guard_q | sticky_q) & !nv_d;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            e_q      <= '0;
            frac_q   <= '0;
            rm_q     <= '0;
            int_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            nan_q    <= 1'b0;
            ovf_q    <= 1'b0;
            mag_q    <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            e_q      <= e_d;
            frac_q   <= frac_d;
            rm_q     <= rm_d;
            int_q    <= int_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            nan_q    <= nan_d;
            ovf_q    <= ovf_d;
            mag_q    <= mag_d;
            q_q      <= q_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            nv_q     <= nv_d;
            nx_q     <= nx_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.nv    = nv_q;
    assign bus.nx    = nx_q;

endmodule

// File: tb/tb_fpu_f2int_rm.sv
// Self-checking bench: a signed 32-bit and an unsigned 16-bit converter checked against
// a real-arithmetic reference model, directed corner values and handshake timing.
module tb_fpu_f2int_rm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_f2int_rm_if #(.OUT_W(32)) if_s32 ();
    fpu_f2int_rm_if #(.OUT_W(16)) if_u16 ();

    fpu_f2int_rm #(.OUT_W(32), .SIGNED_OUT(1)) dut_s32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s32.slave)
    );

    fpu_f2int_rm #(.OUT_W(16), .SIGNED_OUT(0)) dut_u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_u16.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        unit;   // 0: signed 32-bit, 1: unsigned 16-bit
        logic [31:0] b;
        logic [1:0]  rm;
        logic [63:0] q;
        logic        nv;
        logic        nx;
    } dir_t;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

    dir_t dir_tbl [19] = '{
        '{1'b0, 32'h3FC00000, RNE, 64'h2,        1'b0, 1'b1},
        '{1'b0, 32'h3FC00000, RTZ, 64'h1,        1'b0, 1'b1},
        '{1'b0, 32'h40200000, RNE, 64'h2,        1'b0, 1'b1},
        '{1'b0, 32'hC0200000, RDN, 64'hFFFFFFFD, 1'b0, 1'b1},
        '{1'b0, 32'hC0200000, RUP, 64'hFFFFFFFE, 1'b0, 1'b1},
        '{1'b0, 32'h3F000000, RUP, 64'h1,        1'b0, 1'b1},
        '{1'b0, 32'h3F000000, RNE, 64'h0,        1'b0, 1'b1},
        '{1'b0, 32'hCF000000, RNE, 64'h80000000, 1'b0, 1'b0},
        '{1'b0, 32'h4F000000, RNE, 64'h7FFFFFFF, 1'b1, 1'b0},
        '{1'b0, 32'hFF800000, RNE, 64'h80000000, 1'b1, 1'b0},
        '{1'b0, 32'h7FC00000, RNE, 64'h7FFFFFFF, 1'b1, 1'b0},
        '{1'b0, 32'h80000000, RDN, 64'h0,        1'b0, 1'b0},
        '{1'b0, 32'h00000000, RUP, 64'h0,        1'b0, 1'b0},
        '{1'b1, 32'hBF800000, RNE, 64'h0,        1'b1, 1'b0},
        '{1'b1, 32'hBECCCCCD, RTZ, 64'h0,        1'b0, 1'b1},
        '{1'b1, 32'h477FFF00, RNE, 64'hFFFF,     1'b0, 1'b0},
        '{1'b1, 32'h47800000, RNE, 64'hFFFF,     1'b1, 1'b0},
        '{1'b1, 32'h7FC00000, RTZ, 64'hFFFF,     1'b1, 1'b0},
        '{1'b1, 32'h477FFF80, RUP, 64'hFFFF,     1'b1, 1'b0}
    };

    // ---------------- reference model (plain real arithmetic) ----------------
    function automatic real pow2(input int n);
        real v = 1.0;
        if (n >= 0) repeat (n) v = v * 2.0;
        else        repeat (-n) v = v / 2.0;
        return v;
    endfunction

    function automatic real fval(input logic [31:0] f);
        real v;
        if (f[30:23] == 8'd0) v = real'(f[22:0]) * pow2(-149);
        else                  v = (8388608.0 + real'(f[22:0])) * pow2(int'(f[30:23]) - 150);
        return f[31] ? -v : v;
    endfunction

    function automatic real round_rm(input real v, input logic [1:0] rm);
        real f, d;
        case (rm)
            RTZ:     return (v < 0.0) ? $ceil(v) : $floor(v);
            RUP:     return $ceil(v);
            RDN:     return $floor(v);
            default: begin
                f = $floor(v);
                d = v - f;
                if (d > 0.5) return f + 1.0;
                if (d < 0.5) return f;
                return ((longint'(f) % 2) == 0) ? f : f + 1.0;
            end
        endcase
    endfunction

    function automatic void model(input logic [31:0] f, input logic [1:0] rm, input int w,
                                  input bit sgn, output logic [63:0] q, output logic nv,
                                  output logic nx);
        logic [63:0] mask, pos, neg;
        real v, r, hi, lo;
        mask = (64'd1 << w) - 64'd1;
        pos  = sgn ? (64'd1 << (w - 1)) - 64'd1 : mask;
        neg  = sgn ? (64'd1 << (w - 1)) : 64'd0;
        hi   = sgn ? pow2(w - 1) - 1.0 : pow2(w) - 1.0;
        lo   = sgn ? -pow2(w - 1) : 0.0;
        nx   = 1'b0;
        if (f[30:23] == 8'hFF) begin
            nv = 1'b1;
            q  = (f[22:0] != 23'd0) ? pos : (f[31] ? neg : pos);
        end else begin
            v = fval(f);
            r = round_rm(v, rm);
            if (r > hi) begin
                q = pos; nv = 1'b1;
            end else if (r < lo) begin
                q = neg; nv = 1'b1;
            end else begin
                q  = 64'(longint'(r)) & mask;
                nv = 1'b0;
                nx = (r != v);
            end
        end
    endfunction

    // ---------------- drive / sample helpers ----------------
    task automatic drive(input bit unit, input logic do_v, input logic [31:0] bv,
                         input logic [1:0] rm);
        if (unit) begin
            if_u16.do_f2int = do_v; if_u16.b = bv; if_u16.rmode = rm;
        end else begin
            if_s32.do_f2int = do_v; if_s32.b = bv; if_s32.rmode = rm;
        end
    endtask

    task automatic sample(input bit unit, output logic [63:0] q, output logic v,
                          output logic bz, output logic nv, output logic nx);
        if (unit) begin
            q = 64'(if_u16.q); v = if_u16.valid; bz = if_u16.busy; nv = if_u16.nv; nx = if_u16.nx;
        end else begin
            q = 64'(if_s32.q); v = if_s32.valid; bz = if_s32.busy; nv = if_s32.nv; nx = if_s32.nx;
        end
    endtask

    // Presents a start pulse across the next edge (k) and returns the number of edges to valid.
    task automatic start_and_wait(input bit unit, input logic [31:0] bv, input logic [1:0] rm,
                                  output int lat, output logic [63:0] q, output logic nv,
                                  output logic nx);
        logic [63:0] sq;
        logic sv, sb, snv, snx;
        drive(unit, 1'b1, bv, rm);
        @(posedge clk); #1;
        drive(unit, 1'b0, bv, rm);
        lat = -1; q = '0; nv = 1'b0; nx = 1'b0;
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            @(posedge clk); #1;
            sample(unit, sq, sv, sb, snv, snx);
            if (sv) begin
                lat = i; q = sq; nv = snv; nx = snx;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] q; logic v, bz, nv, nx;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 2'd0);
        drive(1'b1, 1'b0, 32'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            sample(u[0], q, v, bz, nv, nx);
            n_checks++;
            if ({q, v, bz, nv, nx} !== 68'd0) begin
                n_fail++;
                $display("FAIL reset_state unit%0d: got q=%h v=%b busy=%b nv=%b nx=%b, want all zero",
                         u, q, v, bz, nv, nx);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat; logic [63:0] q, mq; logic nv, nx, mnv, mnx;
        foreach (dir_tbl[i]) begin
            @(negedge clk);
            start_and_wait(dir_tbl[i].unit, dir_tbl[i].b, dir_tbl[i].rm, lat, q, nv, nx);
            n_checks++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want 3", i, lat);
            end
            n_checks++;
            if ({q, nv, nx} !== {dir_tbl[i].q, dir_tbl[i].nv, dir_tbl[i].nx}) begin
                n_fail++;
                $display("FAIL directed[%0d] b=%h rm=%0d: got q=%h nv=%b nx=%b, want q=%h nv=%b nx=%b",
                         i, dir_tbl[i].b, dir_tbl[i].rm, q, nv, nx,
                         dir_tbl[i].q, dir_tbl[i].nv, dir_tbl[i].nx);
            end
            model(dir_tbl[i].b, dir_tbl[i].rm, dir_tbl[i].unit ? 16 : 32, !dir_tbl[i].unit,
                  mq, mnv, mnx);
            n_checks++;
            if ({q, nv, nx} !== {mq, mnv, mnx}) begin
                n_fail++;
                $display("FAIL directed_model[%0d]: got q=%h nv=%b nx=%b, model q=%h nv=%b nx=%b",
                         i, q, nv, nx, mq, mnv, mnx);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] q, mq; logic nv, nx, mnv, mnx;
        logic [31:0] bv; logic [7:0] e; logic [22:0] fr; logic [1:0] rm;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 250; i++) begin
                e  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(112, 162));
                fr = 23'($urandom) & (23'h7FFFFF << $urandom_range(0, 23));
                bv = {1'($urandom), e, fr};
                rm = 2'($urandom);
                @(negedge clk);
                start_and_wait(u[0], bv, rm, lat, q, nv, nx);
                model(bv, rm, (u == 1) ? 16 : 32, u == 0, mq, mnv, mnx);
                n_checks++;
                if (lat !== 3 || {q, nv, nx} !== {mq, mnv, mnx}) begin
                    n_fail++;
                    $display("FAIL random unit%0d b=%h rm=%0d: got lat=%0d q=%h nv=%b nx=%b, want lat=3 q=%h nv=%b nx=%b",
                             u, bv, rm, lat, q, nv, nx, mq, mnv, mnx);
                end
            end
        end
    endtask

    task automatic test_double_pulse();
        logic [63:0] q, sq, mq; logic sv, sb, snv, snx, nv, nx, mnv, mnx;
        int n_valid = 0, first = -1;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h40200000, RNE);          // 2.5 -> 2
        @(posedge clk); #1;                             // edge k
        drive(1'b0, 1'b1, 32'hC1100000, RTZ);          // -9.0, must be ignored
        @(posedge clk); #1;                             // edge k+1
        drive(1'b0, 1'b0, 32'd0, RNE);
        q = '0; nv = 1'b0; nx = 1'b0;
        for (int i = 2; i < 10; i++) begin
            @(posedge clk); #1;
            sample(1'b0, sq, sv, sb, snv, snx);
            if (sv) begin
                n_valid++;
                if (first < 0) begin first = i; q = sq; nv = snv; nx = snx; end
            end
        end
        n_checks++;
        if (n_valid !== 1 || first !== 3) begin
            n_fail++;
            $display("FAIL double_pulse_valids: got %0d valids first at k+%0d, want 1 at k+3", n_valid, first);
        end
        model(32'h40200000, RNE, 32, 1'b1, mq, mnv, mnx);
        n_checks++;
        if ({q, nv, nx} !== {mq, mnv, mnx}) begin
            n_fail++;
            $display("FAIL double_pulse_result: got q=%h nv=%b nx=%b, want q=%h nv=%b nx=%b",
                     q, nv, nx, mq, mnv, mnx);
        end
    endtask

    task automatic test_back_to_back();
        int lat_a, lat_b; logic [63:0] qa, qb, mq; logic nva, nxa, nvb, nxb, mnv, mnx;
        logic [31:0] ba, bb;
        ba = {1'b1, 8'($urandom_range(120, 150)), 23'($urandom)};
        bb = {1'b0, 8'($urandom_range(120, 150)), 23'($urandom)};
        @(negedge clk);
        start_and_wait(1'b0, ba, RUP, lat_a, qa, nva, nxa);
        // Still inside the valid cycle: the next start is presented before edge k+4.
        start_and_wait(1'b0, bb, RDN, lat_b, qb, nvb, nxb);
        n_checks++;
        if (lat_a !== 3 || lat_b !== 3) begin
            n_fail++;
            $display("FAIL back_to_back_timing: got valids at k+%0d and k+%0d, want k+3 and k+7",
                     lat_a, lat_a + 1 + lat_b);
        end
        model(ba, RUP, 32, 1'b1, mq, mnv, mnx);
        n_checks++;
        if ({qa, nva, nxa} !== {mq, mnv, mnx}) begin
            n_fail++;
            $display("FAIL back_to_back_first: got q=%h nv=%b nx=%b, want q=%h nv=%b nx=%b",
                     qa, nva, nxa, mq, mnv, mnx);
        end
        model(bb, RDN, 32, 1'b1, mq, mnv, mnx);
        n_checks++;
        if ({qb, nvb, nxb} !== {mq, mnv, mnx}) begin
            n_fail++;
            $display("FAIL back_to_back_second: got q=%h nv=%b nx=%b, want q=%h nv=%b nx=%b",
                     qb, nvb, nxb, mq, mnv, mnx);
        end
    endtask

    task automatic test_hold();
        int lat; logic [63:0] q; logic v, bz, nv, nx;
        @(negedge clk);
        start_and_wait(1'b0, 32'h40A00000, RTZ, lat, q, nv, nx);   // 5.0
        n_checks++;
        if (lat !== 3 || {q, nv, nx} !== {64'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_setup: got lat=%0d q=%h nv=%b nx=%b, want lat=3 q=5 nv=0 nx=0", lat, q, nv, nx);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h3FC00000, RTZ);                     // 1.5
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 32'h3FC00000, RTZ);
            sample(1'b0, q, v, bz, nv, nx);
            n_checks++;
            if ({q, v, bz} !== {64'd5, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_in_flight k+%0d: got q=%h valid=%b busy=%b, want q=5 valid=0 busy=1",
                         i, q, v, bz);
            end
        end
        @(posedge clk); #1;
        sample(1'b0, q, v, bz, nv, nx);
        n_checks++;
        if ({q, v, bz, nv, nx} !== {64'd1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_result: got q=%h valid=%b busy=%b nv=%b nx=%b, want q=1 valid=1 busy=0 nv=0 nx=1",
                     q, v, bz, nv, nx);
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_valid = 0; logic [63:0] q, mq; logic v, bz, nv, nx, mnv, mnx;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h3FC00000, RNE);
        @(posedge clk); #1;                                        // edge k
        drive(1'b0, 1'b0, 32'h3FC00000, RNE);
        @(posedge clk); #1;                                        // edge k+1
        rst_n = 1'b0;
        #1;
        sample(1'b0, q, v, bz, nv, nx);
        n_checks++;
        if ({q, v, bz, nv, nx} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got q=%h valid=%b busy=%b nv=%b nx=%b, want all zero",
                     q, v, bz, nv, nx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sample(1'b0, q, v, bz, nv, nx);
            if (v || bz || q !== 64'd0) n_valid++;
        end
        n_checks++;
        if (n_valid !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got %0d cycles with activity or nonzero q, want 0", n_valid);
        end
        @(negedge clk);
        start_and_wait(1'b0, 32'hC0200000, RDN, lat, q, nv, nx);
        model(32'hC0200000, RDN, 32, 1'b1, mq, mnv, mnx);
        n_checks++;
        if (lat !== 3 || {q, nv, nx} !== {mq, mnv, mnx}) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got lat=%0d q=%h nv=%b nx=%b, want lat=3 q=%h nv=%b nx=%b",
                     lat, q, nv, nx, mq, mnv, mnx);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_double_pulse();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
